// File: rtl/signed_multiplier_n.sv
// Sequential shift-and-add multiplier for signed or unsigned WIDTH-bit operands.
// Runs one ADD/SHIFT pair per multiplier bit and leaves the 2*WIDTH-bit product in A:B.
module signed_multiplier_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Load_B,
  input  logic                 Start,
  input  logic                 Signed,
  input  logic [WIDTH-1:0]     Din,
  output logic [WIDTH-1:0]     Aval,
  output logic [WIDTH-1:0]     Bval,
  output logic                 Xval,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Add,
  output logic                 Sub,
  output logic                 Shift
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               x_q, x_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               last_iter;
  logic               add_c, sub_c;
  logic [WIDTH:0]     ext_a, ext_s, sum;

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      x_q     <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    x_d     = x_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;

    last_iter = (cnt_q == LAST_CNT);
    // Final multiplier bit carries negative weight in two's complement
    add_c = (state_q == S_ADD) && b_q[0] && !(last_iter && mode_q);
    sub_c = (state_q == S_ADD) && b_q[0] && last_iter && mode_q;
    ext_a = {mode_q & a_q[WIDTH-1], a_q};
    ext_s = {mode_q & s_q[WIDTH-1], s_q};
    sum   = sub_c ? (ext_a - ext_s) : (ext_a + ext_s);

    case (state_q)
      S_IDLE: begin
        if (Load_B) b_d = Din;
        if (Start) begin
          s_d     = Din;
          a_d     = '0;
          x_d     = 1'b0;
          cnt_d   = '0;
          mode_d  = Signed;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (b_q[0]) {x_d, a_d} = sum;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        x_d     = mode_q & x_q;
        a_d     = {x_q, a_q[WIDTH-1:1]};
        b_d     = {a_q[0], b_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = last_iter ? S_DONE : S_ADD;
      end
      S_DONE: begin
        if (!Start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Aval    = a_q;
  assign Bval    = b_q;
  assign Xval    = x_q;
  assign Product = {a_q, b_q};
  assign Busy    = (state_q == S_ADD) || (state_q == S_SHIFT);
  assign Done    = (state_q == S_DONE);
  assign Add     = add_c;
  assign Sub     = sub_c;
  assign Shift   = (state_q == S_SHIFT);

endmodule

// File: doc/signed_multiplier_n.md
SIGNED_MULTIPLIER_N -- requirements
Module: signed_multiplier_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Load_B, input, 1, load multiplier register B from Din when idle.
REQ-005 SHALL have port Start, input, 1, level request to begin a multiply; same semantics as Run.
REQ-006 SHALL have port Signed, input, 1: 1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port Din, input, WIDTH, operand bus: multiplier on Load_B, multiplicand on Start.
REQ-008 SHALL have port Aval, output, WIDTH, upper product register A.
REQ-009 SHALL have port Bval, output, WIDTH, lower product and multiplier register B.
REQ-010 SHALL have port Xval, output, 1, extension bit above A.
REQ-011 SHALL have port Product, output, 2*WIDTH, equal to {Aval,Bval}.
REQ-012 SHALL have port Busy, output, 1, high in ADD and SHIFT states.
REQ-013 SHALL have port Done, output, 1, high in DONE state.
REQ-014 SHALL have ports Add, Sub, Shift, output, 1 each, high in cycles where A is added to, subtracted from, or X:A:B is shifted.

Function
REQ-015 SHALL implement FSM states IDLE, ADD, SHIFT, DONE plus an iteration counter of ceil(log2(WIDTH)) bits.
REQ-016 IDLE, Load_B=1: B SHALL take Din; A and X unchanged.
REQ-017 IDLE, Start=1: S SHALL take Din, A and X SHALL clear, counter SHALL clear, mode SHALL latch Signed, next state ADD.
REQ-018 IDLE, Start and Load_B both 1: B and S SHALL both take Din (squaring), then proceed as REQ-017.
REQ-019 Load_B and Signed SHALL be ignored outside IDLE; latched mode governs the whole operation.
REQ-020 ADD with B[0]=0: A and X SHALL hold; Add=Sub=0; next state SHALL be SHIFT.
REQ-021 ADD with B[0]=1, not last iteration: {X,A} SHALL take ext(A)+ext(S) as a (WIDTH+1)-bit sum; Add=1.
REQ-022 ADD with B[0]=1, last iteration (counter=WIDTH-1), signed mode: {X,A} SHALL take ext(A)-ext(S); Sub=1.
REQ-023 ext() SHALL be sign extension in signed mode and zero extension in unsigned mode; unsigned mode SHALL never subtract.
REQ-024 SHIFT: {X,A,B} SHALL shift right one bit; X SHALL be replicated in signed mode and cleared to 0 in unsigned mode; Shift=1; counter SHALL increment.
REQ-025 SHIFT with counter=WIDTH-1 SHALL go to DONE; otherwise it SHALL go to ADD.
REQ-026 Latency: with Start sampled at edge k, Done SHALL first be high after edge k+2*WIDTH.
REQ-027 DONE SHALL hold Product stable while Start=1, and SHALL return to IDLE on the first edge with Start=0.
REQ-028 Product SHALL equal the exact 2*WIDTH-bit product, including -2^(WIDTH-1) * -2^(WIDTH-1) in signed mode.
REQ-029 Start held high from IDLE SHALL produce exactly one multiply; a new multiply requires Start to fall and rise again.

Reset
REQ-030 Reset=1 at any edge, in any state including mid-operation, SHALL set state IDLE and zero A, B, S, X, and counter.
REQ-031 Reset SHALL take priority over Start and Load_B in the same cycle.
REQ-032 During and after reset, Busy, Done, Add, Sub, Shift SHALL be 0, and Product SHALL be 0.

Verification
REQ-033 WIDTH=8, Signed=1: Load_B Din=0x07, then Start Din=0xFD -> Done after 16 cycles, Product=0xFFEB, Sub=0 throughout.
REQ-034 WIDTH=8, Signed=1: B=0x80, S=0x80 -> Product=0x4000, Sub pulses once, in the cycle before the final shift.
REQ-035 WIDTH=8, Signed=0: B=0xFF, S=0xFF -> Product=0xFE01, Xval=0 after each shift.
REQ-036 WIDTH=8: Start and Load_B together with Din=0x0C -> Product=0x0090.
REQ-037 WIDTH=16, Signed=1: B=0x8000, S=0x7FFF -> Product=0xC0008000, Done after 32 cycles.
REQ-038 Reset asserted on cycle 5 of a multiply -> next cycle IDLE, Product=0, Busy=0; Start held high through reset -> a fresh multiply begins on the next edge.
